// File: rtl/pixel_pack_ctrl.sv
// pixel_pack_ctrl
//   Packs a stream of 8-bit pixels into 32-bit words (first pixel in the low
//   byte) and writes each word to word-addressed memory at an
//   auto-incrementing address. A short final word is filled with PAD_BYTE.
//   A one-cycle done pulse marks the end of each frame.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : one-cycle frame start pulse, sampled only when idle
//   num_pixels : pixel count of the frame, latched on an accepted start
//   pix_in     : pixel byte
//   pix_valid  : pix_in is valid
//   pix_ready  : pixel accepted this cycle when pix_valid is also high
//   word_out   : packed word {lane3, lane2, lane1, lane0}
//   word_addr  : target word address
//   word_we    : write request, held until word_ack
//   word_ack   : memory accepts the word this cycle
//   busy       : high whenever a frame is in progress
//   done       : one-cycle pulse at end of frame
module pixel_pack_ctrl #(
    parameter int unsigned       ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [7:0]        PAD_BYTE  = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W+1:0] num_pixels,
    input  logic [7:0]        pix_in,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic [31:0]       word_out,
    output logic [ADDR_W-1:0] word_addr,
    output logic              word_we,
    input  logic              word_ack,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [31:0]       PAD_WORD = {4{PAD_BYTE}};
    localparam logic [ADDR_W+1:0] REM_ONE  = {{(ADDR_W+1){1'b0}}, 1'b1};

    logic [1:0]        state;
    logic [1:0]        lane;
    logic [ADDR_W+1:0] remaining;

    // The only unregistered output: ready is a pure decode of the state.
    assign pix_ready = (state == FILL);

    // word_out doubles as the lane storage, so it is always the word being
    // assembled and is naturally stable while a write waits for word_ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lane      <= '0;
            remaining <= '0;
            word_out  <= '0;
            word_addr <= BASE_ADDR;
            word_we   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (num_pixels != '0) begin
                            remaining <= num_pixels;
                            word_addr <= BASE_ADDR;
                            lane      <= '0;
                            word_out  <= PAD_WORD;
                            state     <= FILL;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                FILL: begin
                    if (pix_valid) begin
                        word_out[{lane, 3'b000} +: 8] <= pix_in;
                        lane      <= lane + 2'd1;
                        remaining <= remaining - REM_ONE;
                        // Close the word on a full lane set or on the last pixel.
                        if (lane == 2'd3 || remaining == REM_ONE) begin
                            word_we <= 1'b1;
                            state   <= WRITE;
                        end
                    end
                end

                WRITE: begin
                    if (word_ack) begin
                        word_we   <= 1'b0;
                        word_addr <= word_addr + 1'b1;
                        word_out  <= PAD_WORD;
                        lane      <= '0;
                        if (remaining == '0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= FILL;
                        end
                    end
                end

                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
